// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage pipelined bitwise logic unit with valid/ready
// flow control on both sides, result flags and a saturating count of
// completed output transfers.
//   S1 captures the operands and op select; S2 holds the computed result.
//   in_ready depends combinationally on out_ready only (never on in_valid).
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             parity,
    output logic [CNT_W-1:0] xfer_cnt
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_NOTA = 3'b110;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Stage 1 registers
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [2:0]       s1_op_q, s1_op_d;

    // Stage 2 registers
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             zero_q, zero_d;
    logic             parity_q, parity_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             s2_load;
    logic             s1_load;
    logic             out_fire;
    logic [WIDTH-1:0] result;

    // Handshake qualifiers: S2 frees up when empty or being drained this cycle
    always_comb begin
        out_fire = out_valid_q && out_ready;
        s2_load  = s1_valid_q && (!out_valid_q || out_ready);
        in_ready = !s1_valid_q || s2_load;
        s1_load  = in_valid && in_ready;
    end

    // Bitwise operation selected by the op captured in S1
    always_comb begin
        result = s1_a_q;
        case (s1_op_q)
            OP_AND:  result = s1_a_q & s1_b_q;
            OP_OR:   result = s1_a_q | s1_b_q;
            OP_XOR:  result = s1_a_q ^ s1_b_q;
            OP_NAND: result = ~(s1_a_q & s1_b_q);
            OP_NOR:  result = ~(s1_a_q | s1_b_q);
            OP_XNOR: result = ~(s1_a_q ^ s1_b_q);
            OP_NOTA: result = ~s1_a_q;
            default: result = s1_a_q;
        endcase
    end

    // Next-state for both stages and the transfer counter
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_op_d     = s1_op_q;
        out_valid_d = out_valid_q;
        y_d         = y_q;
        zero_d      = zero_q;
        parity_d    = parity_q;
        cnt_d       = cnt_q;

        // S1 empties when its item moves on, refills on an input transfer
        if (s2_load) begin
            s1_valid_d = 1'b0;
        end
        if (s1_load) begin
            s1_valid_d = 1'b1;
            s1_a_d     = a;
            s1_b_d     = b;
            s1_op_d    = op;
        end

        // Flags are derived from the same value loaded into y so they stay coherent
        if (out_fire) begin
            out_valid_d = 1'b0;
        end
        if (s2_load) begin
            out_valid_d = 1'b1;
            y_d         = result;
            zero_d      = (result == '0);
            parity_d    = ^result;
        end

        // Counter sticks at its maximum rather than wrapping
        if (out_fire && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers; reset discards any in-flight items
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= '0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            zero_q      <= 1'b1;
            parity_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_q     <= s1_op_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            zero_q      <= zero_d;
            parity_q    <= parity_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign zero      = zero_q;
    assign parity    = parity_q;
    assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: three instances share one stimulus stream
// (WIDTH=8/CNT_W=16 main, CNT_W=4 for saturation, WIDTH=1 for bit-level ops).
// Expected results come from a queue of in-flight items built from the op table.
module tb_logic_unit_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;

    logic        in_ready, out_valid, zero, parity;
    logic [7:0]  y;
    logic [15:0] xfer_cnt;

    logic        in_ready_s, out_valid_s, zero_s, parity_s;
    logic [7:0]  y_s;
    logic [3:0]  xfer_cnt_s;

    logic        in_ready_1, out_valid_1, zero_1, parity_1;
    logic [0:0]  y_1;
    logic [15:0] xfer_cnt_1;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .zero(zero), .parity(parity), .xfer_cnt(xfer_cnt)
    );

    logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .a(a), .b(b), .op(op), .out_valid(out_valid_s), .out_ready(out_ready),
        .y(y_s), .zero(zero_s), .parity(parity_s), .xfer_cnt(xfer_cnt_s)
    );

    logic_unit_pipe #(.WIDTH(1), .CNT_W(16)) dut_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_1),
        .a(a[0:0]), .b(b[0:0]), .op(op), .out_valid(out_valid_1), .out_ready(out_ready),
        .y(y_1), .zero(zero_1), .parity(parity_1), .xfer_cnt(xfer_cnt_1)
    );

    typedef struct {
        logic [7:0] y;
        int         stamp;
    } exp_t;

    exp_t       q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         n_out = 0;
    bit         lat_chk = 0;
    logic [7:0] cur_a, cur_b;
    logic [2:0] cur_op;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] ref_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
        case (o)
            3'd0:    return x & z;
            3'd1:    return x | z;
            3'd2:    return x ^ z;
            3'd3:    return ~(x & z);
            3'd4:    return ~(x | z);
            3'd5:    return ~(x ^ z);
            3'd6:    return ~x;
            default: return x;
        endcase
    endfunction

    // One clock cycle: drive, check against the model, advance the model, clock.
    task automatic step(input logic iv, input logic ordy, output bit acc);
        bit   exp_ov, exp_ir, out_fire, in_fire;
        int   sat;
        in_valid  = iv;
        out_ready = ordy;
        a  = cur_a;
        b  = cur_b;
        op = cur_op;
        #1;
        exp_ir = (q.size() < 2) || ordy;
        exp_ov = (q.size() > 0) && (q[0].stamp <= cyc - 2);
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
        check("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
        check("out_valid_w1", {31'd0, out_valid_1}, {31'd0, exp_ov});
        check("in_ready_sat", {31'd0, in_ready_s}, {31'd0, exp_ir});
        if (exp_ov) begin
            check("y", {24'd0, y}, {24'd0, q[0].y});
            check("zero", {31'd0, zero}, {31'd0, (q[0].y == 8'd0)});
            check("parity", {31'd0, parity}, {31'd0, ^q[0].y});
            check("y_w1", {31'd0, y_1}, {31'd0, q[0].y[0]});
            check("zero_w1", {31'd0, zero_1}, {31'd0, ~q[0].y[0]});
        end
        sat = (n_out > 15) ? 15 : n_out;
        check("xfer_cnt", {16'd0, xfer_cnt}, n_out);
        check("xfer_cnt_sat", {28'd0, xfer_cnt_s}, sat);
        out_fire = exp_ov && ordy;
        in_fire  = iv && exp_ir;
        if (out_fire) begin
            if (lat_chk) check("latency", cyc - q[0].stamp, 2);
            void'(q.pop_front());
            n_out++;
        end
        if (in_fire) q.push_back('{ref_op(cur_op, cur_a, cur_b), cyc});
        acc = in_fire;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 20 && q.size() > 0; i++) step(1'b0, 1'b1, acc);
        check("drain_empty", q.size(), 0);
    endtask

    // Asynchronous reset mid-cycle, checked before any clock edge arrives.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_y", {24'd0, y}, 0);
        check("rst_zero", {31'd0, zero}, 1);
        check("rst_parity", {31'd0, parity}, 0);
        check("rst_xfer_cnt", {16'd0, xfer_cnt}, 0);
        q.delete();
        n_out = 0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 1);
    endtask

    initial begin
        bit acc;
        int accepted;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = '0;
        cur_a = '0; cur_b = '0; cur_op = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Op sweep, back-to-back, consumer always ready
        lat_chk = 1;
        cur_a = 8'hC5; cur_b = 8'h3A;
        for (int o = 0; o < 8; o++) begin
            cur_op = o[2:0];
            step(1'b1, 1'b1, acc);
            check("sweep_accept", {31'd0, acc}, 1);
        end
        drain();
        lat_chk = 0;
        check("sweep_cnt", {16'd0, xfer_cnt}, 8);

        // Backpressure: 4 XOR items, consumer stalled first
        do_reset();
        accepted = 0;
        cur_op = 3'd2; cur_a = 8'($urandom); cur_b = 8'($urandom);
        for (int i = 0; i < 5; i++) begin
            step(accepted < 4, 1'b0, acc);
            if (acc) begin
                accepted++;
                cur_a = 8'($urandom); cur_b = 8'($urandom);
            end
        end
        check("bp_accepted", accepted, 2);
        for (int i = 0; i < 20 && accepted < 4; i++) begin
            step(1'b1, 1'b1, acc);
            if (acc) begin
                accepted++;
                cur_a = 8'($urandom); cur_b = 8'($urandom);
            end
        end
        drain();
        check("bp_cnt", {16'd0, xfer_cnt}, 4);

        // Alternating drain/fill with random items, 200 results
        do_reset();
        cur_a = 8'($urandom); cur_b = 8'($urandom); cur_op = 3'($urandom);
        for (int i = 0; i < 2000 && n_out < 200; i++) begin
            step(1'b1, i[0] == 1'b0, acc);
            if (acc) begin
                cur_a = 8'($urandom); cur_b = 8'($urandom); cur_op = 3'($urandom);
            end
        end
        check("alt_count", n_out, 200);
        check("alt_xfer_cnt", {16'd0, xfer_cnt}, 200);
        check("sat_hold", {28'd0, xfer_cnt_s}, 15);

        // Reset with items still in flight, then 1-bit exhaustive ops 0..5
        do_reset();
        for (int o = 0; o < 6; o++) begin
            for (int v = 0; v < 4; v++) begin
                cur_op = o[2:0];
                cur_a = {7'($urandom), v[1]};
                cur_b = {7'($urandom), v[0]};
                step(1'b1, 1'b1, acc);
                check("w1_accept", {31'd0, acc}, 1);
            end
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
